branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, SHALL set the number of table entries; it SHALL be a power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 32, SHALL set the PC and target width in bits.
REQ-003 Parameter CNT_W, default 2, SHALL set the saturating-counter width in bits; it SHALL be at least 1.
REQ-004 Parameter STAT_W, default 32, SHALL set the mispredict statistics counter width in bits.
REQ-005 Derived IDX_W = log2(ENTRIES), TAG_W = ADDR_W-IDX_W-2 SHALL be computed internally.
REQ-006 clk_i  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-007 rst_i  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 lookup_pc_i  in  ADDR_W  SHALL be the IF-stage fetch PC.
REQ-009 pred_taken_o  out  1  SHALL be the taken prediction for lookup_pc_i.
REQ-010 pred_target_o  out  ADDR_W  SHALL be the predicted target; it SHALL be 0 when pred_taken_o=0.
REQ-011 upd_valid_i  in  1  SHALL qualify a resolved branch from ID.
REQ-012 upd_pc_i  in  ADDR_W  SHALL be the PC of the resolved branch.
REQ-013 upd_taken_i  in  1  SHALL be the actual branch outcome.
REQ-014 upd_target_i  in  ADDR_W  SHALL be the actual branch target.
REQ-015 upd_mispred_i  in  1  SHALL flag that the resolved branch was mispredicted.
REQ-016 clear_i  in  1  SHALL request invalidation of all entries.
REQ-017 mispred_cnt_o  out  STAT_W  SHALL be the count of mispredicts.

Function
REQ-018 Each entry SHALL hold valid, tag[TAG_W], counter[CNT_W], target[ADDR_W].
REQ-019 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[ADDR_W-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-020 Lookup SHALL be combinational (zero latency): hit = valid and tag match; pred_taken_o = hit and counter MSB=1.
REQ-021 Update SHALL take effect at the clock edge on which upd_valid_i=1 and be visible to lookup from the next cycle.
REQ-022 Same-cycle lookup and update of one index SHALL return the pre-update entry (no bypass).
REQ-023 Update hit, taken: counter SHALL increment, saturating at all-ones; target SHALL be overwritten with upd_target_i.
REQ-024 Update hit, not taken: counter SHALL decrement, saturating at 0; target SHALL be unchanged.
REQ-025 Update miss, taken: entry SHALL be allocated (replacing any occupant) with valid=1, new tag, counter=weakly taken (MSB=1, rest 0), target=upd_target_i.
REQ-026 Update miss, not taken: table SHALL be unchanged.
REQ-027 clear_i=1 SHALL invalidate all entries at the next edge; counters and targets need not change.
REQ-028 clear_i and upd_valid_i together: clear SHALL win; no entry SHALL be valid afterwards.
REQ-029 mispred_cnt_o SHALL increment by 1 on each edge with upd_valid_i=1 and upd_mispred_i=1, saturating at all-ones; clear_i SHALL NOT reset it.
REQ-030 upd_mispred_i with upd_valid_i=0 SHALL be ignored.

Reset
REQ-031 rst_i=0 SHALL asynchronously clear all valid bits, counters, targets, tags and mispred_cnt_o to 0.
REQ-032 While rst_i=0, pred_taken_o SHALL be 0 and pred_target_o SHALL be 0; updates SHALL be ignored.
REQ-033 Reset asserted mid-update SHALL discard that update; release SHALL resume on the first rising edge with rst_i=1.

Verification
REQ-034 Reset, then lookup 0x40 -> pred_taken_o=0, pred_target_o=0, mispred_cnt_o=0.
REQ-035 Update pc=0x40, taken, target=0x100 -> next cycle lookup 0x40 gives taken, 0x100; counter=2'b10.
REQ-036 Two not-taken updates at 0x40 after REQ-035 -> counter 2'b00, pred_taken_o=0; third not-taken keeps 2'b00; four taken updates saturate at 2'b11.
REQ-037 ENTRIES=16: allocate 0x40 then taken update at 0x80 (same index, different tag) -> lookup 0x40 misses, 0x80 hits with new target.
REQ-038 Same-cycle clear_i and taken update at 0x40 -> next cycle lookup 0x40 misses; mispred_cnt_o unchanged.
REQ-039 STAT_W=2, four mispredict updates -> mispred_cnt_o reads 1,2,3,3; async rst_i low mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with saturating counters
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  input  logic              clear_i,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  // Weakly taken: MSB set, all lower bits clear.
  localparam logic [CNT_W-1:0]  CNT_WEAK = ~(CNT_MAX >> 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [STAT_W-1:0] mispred_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

  // Instruction-aligned PCs: the byte-offset bits never participate.
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // Zero-latency lookup against the registered table; no bypass from a same-cycle update.
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    pred_target_o = pred_taken_o ? target_q[lk_idx] : '0;
  end

  // Hit detection for the resolving branch.
  always_comb begin
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  // Table state: clear beats update; taken misses allocate, not-taken misses are dropped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          if (cnt_q[up_idx] != CNT_MAX) begin
            cnt_q[up_idx] <= cnt_q[up_idx] + 1'b1;
          end
          target_q[up_idx] <= upd_target_i;
        end else if (cnt_q[up_idx] != '0) begin
          cnt_q[up_idx] <= cnt_q[up_idx] - 1'b1;
        end
      end else if (upd_taken_i) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        cnt_q[up_idx]    <= CNT_WEAK;
        target_q[up_idx] <= upd_target_i;
      end
    end
  end

  // Saturating mispredict statistic; survives table clears.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mispred_q <= '0;
    end else if (upd_valid_i && upd_mispred_i && (mispred_q != STAT_MAX)) begin
      mispred_q <= mispred_q + 1'b1;
    end
  end

  assign mispred_cnt_o = mispred_q;

endmodule
